// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types for the fetch stage: NOP encoding, FSM states
// and the {address, instruction} buffer entry.
package instruction_fetch_unit_pkg;

  localparam int ILEN = 32;
  localparam logic [ILEN-1:0] NOP_INSTRUCTION = 32'h0000_0013;

  typedef enum logic {
    FETCH = 1'b0,
    FLUSH = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0]     addr;
    logic [ILEN-1:0] insn;
  } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_unit_buffer.sv
// In-order buffer of fetched words with their addresses.
// Flush wins over push and pop in the same cycle.
module fetch_instruction_buffer
  import instruction_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  fetch_entry_t  push_entry,
  input  logic          pop,
  input  logic          flush,
  output fetch_entry_t  head,
  output logic [CW-1:0] count,
  output logic          empty
);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q != CW'(DEPTH)) || do_pop);

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (flush) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + AW'(1);
      if (do_pop)  rd_d = rd_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_q] <= push_entry;
  end

  assign head  = mem_q[rd_q];
  assign count = count_q;
  assign empty = (count_q == '0);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC, request credits, stale-response flush FSM
// and the decode-side handshake.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_ADDRESS = 32'h0000_0000,
  parameter int          BUFFER_DEPTH  = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [31:0]     redirect_address,
  output logic            memory_request_valid,
  input  logic            memory_request_ready,
  output logic [31:0]     memory_request_addr,
  input  logic            memory_response_valid,
  input  logic [ILEN-1:0] memory_response_data,
  output logic            instruction_valid,
  input  logic            decode_ready,
  output logic [ILEN-1:0] instruction,
  output logic [31:0]     instruction_address
);

  localparam int CW = $clog2(BUFFER_DEPTH + 1);
  localparam logic [CW-1:0] CMAX = '1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   raddr_q, raddr_d;
  logic [CW-1:0] outs_q, outs_d;
  logic [CW-1:0] stale_q, stale_d;
  logic [CW-1:0] outs_left;
  logic [CW:0]   used;
  logic [31:0]   redir_pc;
  logic          req_fire, resp_ok;
  logic          push, pop, flush, empty;
  logic [CW-1:0] count;
  fetch_entry_t  head, push_entry;

  assign used = {1'b0, count} + {1'b0, outs_q};

  // requests stay low while reset is held
  assign memory_request_valid = reset && (state_q == FETCH)
    && !redirect_valid && (used < (CW+1)'(BUFFER_DEPTH));
  assign memory_request_addr = pc_q;

  assign req_fire  = memory_request_valid && memory_request_ready;
  assign resp_ok   = memory_response_valid && (outs_q != '0);
  assign outs_left = resp_ok ? outs_q - CW'(1) : outs_q;
  assign redir_pc  = {redirect_address[31:2], 2'b00};
  assign pop       = !empty && decode_ready && !redirect_valid;
  assign push_entry = '{addr: raddr_q, insn: memory_response_data};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    raddr_d = raddr_q;
    outs_d  = outs_q;
    stale_d = stale_q;
    push    = 1'b0;
    flush   = 1'b0;
    if (redirect_valid) begin
      flush   = 1'b1;
      pc_d    = redir_pc;
      raddr_d = redir_pc;
      outs_d  = outs_left;
      stale_d = outs_left;
      state_d = (state_q == FLUSH || outs_left != '0) ? FLUSH : FETCH;
    end else begin
      outs_d = outs_left;
      if (req_fire) begin
        pc_d = pc_q + 32'd4;
        if (outs_left != CMAX) outs_d = outs_left + CW'(1);
      end
      if (resp_ok) begin
        if (stale_q != '0) begin
          stale_d = stale_q - CW'(1);
        end else begin
          push    = 1'b1;
          raddr_d = raddr_q + 32'd4;
        end
      end
      if (state_q == FLUSH && stale_d == '0) state_d = FETCH;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_ADDRESS;
      raddr_q <= RESET_ADDRESS;
      outs_q  <= '0;
      stale_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      raddr_q <= raddr_d;
      outs_q  <= outs_d;
      stale_q <= stale_d;
    end
  end

  fetch_instruction_buffer #(
    .DEPTH(BUFFER_DEPTH)
  ) u_buf (
    .clk        (clk),
    .rst_n      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (flush),
    .head       (head),
    .count      (count),
    .empty      (empty)
  );

  assign instruction_valid   = !empty;
  assign instruction         = empty ? NOP_INSTRUCTION : head.insn;
  assign instruction_address = empty ? 32'd0 : head.addr;

endmodule
